// File: rtl/hilo_div_sequencer.sv
// HI/LO register owner and multi-cycle restoring divider for the MIPS core.
// Accepts div/divu from decode, iterates one quotient bit per cycle, applies
// sign correction, and stalls decode while HI/LO are still being produced.
module hilo_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             read_hilo,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Division datapath; only meaningful while a division is in flight.
  logic [WIDTH:0]   rem;       // partial remainder, one guard bit
  logic [WIDTH-1:0] quo;       // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_orig;  // raw dividend, returned as HI on divide-by-zero
  logic             q_neg;
  logic             r_neg;
  logic             dvs_zero;

  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;

  // Operand magnitude: two's-complement absolute value only for signed ops.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // Sign correction applied to the unsigned quotient/remainder.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign busy  = (state != IDLE);
  assign stall = busy & (read_hilo | div_start);

  // One restoring step: shift in next dividend bit, trial-subtract the divisor.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {2'b00, dvs_mag};
  end

  // Control FSM and architectural HI/LO registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            state <= DIVIDE;
            cnt   <= '0;
          end
        end
        DIVIDE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) state <= FIXUP;
        end
        FIXUP: begin
          hi    <= dvs_zero ? dvd_orig : apply_sign(rem[WIDTH-1:0], r_neg);
          lo    <= dvs_zero ? '1       : apply_sign(quo, q_neg);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture on acceptance, then the iterative divide steps.
  always_ff @(posedge clock) begin
    if (state == IDLE && div_start) begin
      quo      <= magnitude(dividend, div_signed);
      dvs_mag  <= magnitude(divisor, div_signed);
      rem      <= '0;
      dvd_orig <= dividend;
      q_neg    <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg    <= div_signed & dividend[WIDTH-1];
      dvs_zero <= (divisor == '0);
    end else if (state == DIVIDE) begin
      if (!diff[WIDTH+1]) begin
        rem <= diff[WIDTH:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= trial[WIDTH:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: doc/hilo_div_sequencer.md
Name: hilo_div_sequencer

Overview:
Multi-cycle divide unit and HI/LO register controller for the pipelined MIPS core.
- Accepts div/divu issued from decode and runs an iterative restoring division over WIDTH cycles.
- Owns the architectural HI/LO registers.
- Generates a pipeline stall when mfhi/mflo (or a second div) reaches decode while a division is still in flight.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count of the divide loop.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
div_start  input  1  decode holds a div/divu (SPECIAL opcode, funct div/divu) this cycle.
div_signed  input  1  1 = div (signed), 0 = divu; sampled with div_start.
dividend  input  WIDTH  rs value; sampled with div_start.
divisor  input  WIDTH  rt value; sampled with div_start.
read_hilo  input  1  decode holds mfhi or mflo this cycle.
stall  output  1  freeze fetch/decode this cycle.
busy  output  1  division in progress.
done  output  1  one-cycle pulse: HI/LO just updated.
hi  output  WIDTH  HI register (remainder).
lo  output  WIDTH  LO register (quotient).

Behaviour:
- Reset values: state IDLE, busy 0, done 0, stall 0, hi 0, lo 0, iteration counter 0. Reset mid-division aborts it; HI/LO return to 0.
- FSM states and transitions:
  - IDLE -> DIVIDE when div_start=1. Capture operand magnitudes: abs() if div_signed, else raw. Record quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign). Record the divisor==0 flag. Counter = 0.
  - DIVIDE: one restoring step per cycle, MSB-first. Partial remainder is WIDTH+1 bits. Counter increments each cycle. After the WIDTH-th step, go to FIXUP.
  - FIXUP: apply sign correction (two's-complement negate where the recorded sign is 1). Write hi = remainder, lo = quotient on this edge. Go to IDLE.
  - done = 1 in the IDLE cycle immediately following FIXUP, then 0.
- Latency: div_start sampled at edge E0. DIVIDE occupies cycles E0+1..E0+WIDTH, FIXUP occupies E0+WIDTH+1, and new hi/lo are visible with done=1 at E0+WIDTH+2. Total WIDTH+2 cycles.
- busy = (state != IDLE), combinational from state.
- stall = busy & (read_hilo | div_start), combinational.
  - stall is 0 in the done cycle, so a waiting mfhi/mflo reads the new value that cycle.
  - read_hilo while IDLE never stalls.
- div_start while busy is not accepted. Stall holds decode, and the request is accepted in the first IDLE cycle (the done cycle).
- div_start and read_hilo together in IDLE: the division starts; stall = 0 in that cycle and read_hilo sees the old HI/LO. Decode guarantees one instruction per cycle, so this pair does not occur in practice.
- Arithmetic rules:
  - Signed division truncates toward zero. Remainder takes the dividend's sign.
  - Signed -2^(WIDTH-1) / -1 gives lo = 0x80000000, hi = 0 (WIDTH=32); no trap.
  - Divisor zero (signed or unsigned): hi = dividend (original, uncorrected), lo = all ones. Full latency still applies.
- hi/lo change only on the FIXUP edge and on reset.

Test Plan:
- div_signed=1, 100 / 7, read_hilo idle -> busy for 33 cycles, done pulse at E0+34 with lo=14, hi=2; then busy=0.
- div_signed=1, -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- div_signed=0, 0xFFFFFFFF / 2 -> lo=0x7FFFFFFF, hi=1. Divisor 0 with dividend 0x1234 -> hi=0x1234, lo=0xFFFFFFFF after 34 cycles.
- Start a div, then hold read_hilo=1 from E0+1 -> stall=1 at E0+1..E0+33, stall=0 at E0+34 with new hi/lo visible. Second div_start held during busy is accepted only at E0+34.
- Assert reset at E0+10 -> next cycle busy=0, stall=0, hi=lo=0, done never pulses. A fresh div afterward completes normally.
